// File: rtl/full_subtractor_3_pkg.sv
// Shared types and the single-bit subtract function for the full_subtractor_3 slice.
package full_subtractor_3_pkg;

    typedef struct packed {
        logic d;
        logic b;
    } fs_result_t;

    // One-bit x - y - z: difference and borrow-out.
    function automatic fs_result_t fs_eval(input logic x, input logic y, input logic z);
        fs_result_t r;
        r.d = x ^ y ^ z;
        r.b = (~x & y) | (~x & z) | (y & z);
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational one-bit full subtractor lane.
module full_subtractor_cell
    import full_subtractor_3_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic b
);

    fs_result_t res;

    always_comb begin
        res = fs_eval(x, y, z);
    end

    assign d = res.d;
    assign b = res.b;

endmodule

// File: rtl/full_subtractor_3.sv
// WIDTH independent registered full-subtractor lanes with a tracking valid strobe.
module full_subtractor_3
    import full_subtractor_3_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] b,
    output logic             out_valid
);

    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] b_c;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        full_subtractor_cell u_cell (
            .x (x[i]),
            .y (y[i]),
            .z (z[i]),
            .d (d_c[i]),
            .b (b_c[i])
        );
    end

    // Results update only on valid samples; out_valid follows in_valid every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d <= d_c;
                b <= b_c;
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor_3.sv
// Self-checking bench for full_subtractor_3 at WIDTH=8 against an arithmetic reference.
module tb_full_subtractor_3;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] d;
    logic [W-1:0] b;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_d;
    logic [W-1:0] exp_b;
    logic         exp_v;

    always #5 clk = ~clk;

    full_subtractor_3 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .z         (z),
        .d         (d),
        .b         (b),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: per lane v = x - y - z in [-2,1]; D = v mod 2, B = (v < 0), so v = D - 2B.
    task automatic model(input logic iv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [W-1:0] zv);
        exp_v = iv;
        if (iv) begin
            for (int i = 0; i < int'(W); i++) begin
                int v;
                v = int'(xv[i]) - int'(yv[i]) - int'(zv[i]);
                exp_b[i] = (v < 0);
                exp_d[i] = 1'((v + 2) % 2);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_b"}, b, exp_b);
        check({tag, "_v"}, W'(out_valid), W'(exp_v));
    endtask

    task automatic model_reset();
        exp_d = '0;
        exp_b = '0;
        exp_v = 1'b0;
    endtask

    // Drive on the falling edge, capture on the rising edge, compare just after it.
    task automatic step(input string tag, input logic iv, input logic [W-1:0] xv,
                        input logic [W-1:0] yv, input logic [W-1:0] zv);
        @(negedge clk);
        in_valid = iv;
        x = xv;
        y = yv;
        z = zv;
        @(posedge clk);
        model(iv, xv, yv, zv);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [2:0] k;
        rst      = 1'b1;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        z = '0;
        model_reset();
        #1;
        check_outputs("por");
        #1 rst = 1'b0;

        // Load nonzero state, then assert reset between edges.
        step("preload", 1'b1, 8'h00, 8'hff, 8'hff);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 8'h00;
            y = 8'hff;
            z = 8'h00;
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Exhaustive xyz sweep replicated across all lanes.
        for (int n = 0; n < 8; n++) begin
            k = 3'(n);
            step("sweep", 1'b1, {W{k[2]}}, {W{k[1]}}, {W{k[0]}});
        end
        check("sweep_last_d", d, 8'hff);
        check("sweep_last_b", b, 8'hff);

        // Hold: invalid sample must not disturb d/b.
        step("hold", 1'b0, 8'hff, 8'h00, 8'h00);
        check("hold_d", d, 8'hff);

        // Lane independence on the low nibble.
        step("lanes", 1'b1, 8'h0a, 8'h06, 8'h03);
        check("lanes_d", d, 8'h0f);
        check("lanes_b", b, 8'h07);

        // Mid-stream reset: outputs clear at once, stream resumes cleanly.
        step("stream0", 1'b1, 8'h5a, 8'h3c, 8'h0f);
        step("stream1", 1'b1, 8'ha5, 8'hc3, 8'hf0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_rst");
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("mid_rst_edge");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        step("post_rst_idle", 1'b0, 8'hff, 8'hff, 8'hff);
        step("post_rst0", 1'b1, 8'h12, 8'h34, 8'h56);
        step("post_rst1", 1'b1, 8'hfe, 8'h01, 8'h80);

        // Randomized traffic.
        for (int n = 0; n < 1000; n++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
